// File: rtl/lcd_pkg.sv
// Panel strap codes, IDs, resolutions and FSM state shared by the LCD init path.
// Latency: n/a (declarations only). Backpressure: n/a.
package lcd_pkg;

    localparam logic [15:0] ID_4342 = 16'h4342;
    localparam logic [15:0] ID_7084 = 16'h7084;
    localparam logic [15:0] ID_7016 = 16'h7016;
    localparam logic [15:0] ID_4384 = 16'h4384;
    localparam logic [15:0] ID_1018 = 16'h1018;

    localparam logic [2:0] STRAP_4342 = 3'b000;
    localparam logic [2:0] STRAP_7084 = 3'b001;
    localparam logic [2:0] STRAP_7016 = 3'b010;
    localparam logic [2:0] STRAP_4384 = 3'b100;
    localparam logic [2:0] STRAP_1018 = 3'b101;

    typedef enum logic [2:0] {
        ST_HOLD,
        ST_SAMPLE,
        ST_RELEASE,
        ST_RUN,
        ST_ERR
    } state_t;

    typedef struct packed {
        logic        valid;
        logic [15:0] id;
        logic [10:0] h;
        logic [10:0] v;
    } panel_t;

    localparam panel_t PANEL_DEFAULT = '{valid: 1'b1, id: ID_4342, h: 11'd480, v: 11'd272};

    function automatic panel_t id_decode(input logic [2:0] m);
        panel_t p;
        p = '{valid: 1'b0, id: 16'h0000, h: 11'd0, v: 11'd0};
        case (m)
            STRAP_4342: p = PANEL_DEFAULT;
            STRAP_7084: p = '{valid: 1'b1, id: ID_7084, h: 11'd800,  v: 11'd480};
            STRAP_7016: p = '{valid: 1'b1, id: ID_7016, h: 11'd1024, v: 11'd600};
            STRAP_4384: p = '{valid: 1'b1, id: ID_4384, h: 11'd800,  v: 11'd480};
            STRAP_1018: p = '{valid: 1'b1, id: ID_1018, h: 11'd1280, v: 11'd800};
            default:    p = '{valid: 1'b0, id: 16'h0000, h: 11'd0, v: 11'd0};
        endcase
        return p;
    endfunction

endpackage

// File: rtl/lcd_bl_pwm.sv
// Backlight PWM: free-running 8-bit counter compared against a duty that ramps one LSB per RAMP_STEP.
// Latency: lcd_bl registered, one cycle behind duty. Backpressure: none; target sampled every cycle.
module lcd_bl_pwm #(
    parameter int RAMP_STEP = 256
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       enable,
    input  logic       clr,
    input  logic [7:0] target,
    output logic       lcd_bl
);

    localparam int SW = $clog2(RAMP_STEP) + 1;

    logic [7:0]    pc_q, pc_d;
    logic [7:0]    duty_q, duty_d;
    logic [SW-1:0] step_q, step_d;
    logic          lcd_bl_q, lcd_bl_d;

    always_comb begin
        pc_d   = pc_q + 8'd1;
        duty_d = duty_q;
        step_d = '0;
        if (clr) begin
            duty_d = 8'd0;
        end else if (enable && (duty_q != target)) begin
            // Direction is re-evaluated every step, so a new target mid-ramp simply retargets.
            if (step_q == SW'(RAMP_STEP - 1)) begin
                duty_d = (target > duty_q) ? duty_q + 8'd1 : duty_q - 8'd1;
            end else begin
                step_d = step_q + SW'(1);
            end
        end
        lcd_bl_d = enable && !clr && (pc_q < duty_q);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q     <= 8'd0;
            duty_q   <= 8'd0;
            step_q   <= '0;
            lcd_bl_q <= 1'b0;
        end else begin
            pc_q     <= pc_d;
            duty_q   <= duty_d;
            step_q   <= step_d;
            lcd_bl_q <= lcd_bl_d;
        end
    end

    assign lcd_bl = lcd_bl_q;

endmodule

// File: rtl/lcd_init_ctrl.sv
// LCD power-up sequencer: hold reset, read panel straps 3x, release, enable driver, ramp backlight.
// Latency: all outputs registered; drv_en nominally 13003 cycles after rst. Backpressure: none.
module lcd_init_ctrl
    import lcd_pkg::*;
#(
    parameter int RST_HOLD     = 5000,
    parameter int SAMPLE_GAP   = 1000,
    parameter int RELEASE_WAIT = 5000,
    parameter int RAMP_STEP    = 256
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] lcd_rgb_in,
    input  logic [7:0]  bl_level,
    input  logic        reinit,
    output logic        rgb_oe,
    output logic        lcd_rst,
    output logic        drv_en,
    output logic        lcd_bl,
    output logic [15:0] id_lcd,
    output logic [10:0] h_disp,
    output logic [10:0] v_disp,
    output logic        init_done,
    output logic        id_err
);

    localparam int PW = $clog2((RST_HOLD > RELEASE_WAIT) ? RST_HOLD : RELEASE_WAIT) + 1;
    localparam int GW = $clog2(SAMPLE_GAP) + 1;

    state_t        state_q, state_d;
    logic [PW-1:0] cnt_q, cnt_d;
    logic [GW-1:0] gap_q, gap_d;
    logic [1:0]    nsmp_q, nsmp_d;
    logic [1:0]    att_q, att_d;
    logic [2:0]    s0_q, s0_d, s1_q, s1_d, s2_q, s2_d;
    logic [15:0]   id_q, id_d;
    logic [10:0]   h_q, h_d, v_q, v_d;
    logic          lcd_rst_q, lcd_rst_d;
    logic          run_q, run_d;
    logic          id_err_q, id_err_d;

    logic [2:0]    strap;
    panel_t        dec;
    logic          match;
    logic          reinit_ok;
    logic          rgb_unused;

    assign strap = {lcd_rgb_in[4], lcd_rgb_in[10], lcd_rgb_in[15]};
    // The other bus bits carry pixel data once the driver is enabled, never straps.
    assign rgb_unused = ^{lcd_rgb_in[14:11], lcd_rgb_in[9:5], lcd_rgb_in[3:0]};

    always_comb begin
        dec       = id_decode(s0_q);
        match     = (s0_q == s1_q) && (s1_q == s2_q) && dec.valid;
        reinit_ok = reinit && ((state_q == ST_RUN) || (state_q == ST_ERR));

        state_d = state_q;
        cnt_d   = '0;
        gap_d   = '0;
        nsmp_d  = nsmp_q;
        att_d   = att_q;
        s0_d    = s0_q;
        s1_d    = s1_q;
        s2_d    = s2_q;
        id_d    = id_q;
        h_d     = h_q;
        v_d     = v_q;

        case (state_q)
            ST_HOLD: begin
                cnt_d  = cnt_q + PW'(1);
                nsmp_d = 2'd0;
                if (cnt_q == PW'(RST_HOLD)) begin
                    state_d = ST_SAMPLE;
                    cnt_d   = '0;
                end
            end
            ST_SAMPLE: begin
                if (nsmp_q == 2'd3) begin
                    // Decision cycle after the third sample of an attempt.
                    nsmp_d = 2'd0;
                    if (match) begin
                        state_d = ST_RELEASE;
                        id_d    = dec.id;
                        h_d     = dec.h;
                        v_d     = dec.v;
                    end else if (att_q == 2'd2) begin
                        state_d = ST_ERR;
                        att_d   = 2'd3;
                        id_d    = PANEL_DEFAULT.id;
                        h_d     = PANEL_DEFAULT.h;
                        v_d     = PANEL_DEFAULT.v;
                    end else begin
                        att_d = att_q + 2'd1;
                    end
                end else if (gap_q == GW'(SAMPLE_GAP - 1)) begin
                    nsmp_d = nsmp_q + 2'd1;
                    case (nsmp_q)
                        2'd0:    s0_d = strap;
                        2'd1:    s1_d = strap;
                        default: s2_d = strap;
                    endcase
                end else begin
                    gap_d = gap_q + GW'(1);
                end
            end
            ST_RELEASE: begin
                cnt_d = cnt_q + PW'(1);
                if (cnt_q == PW'(RELEASE_WAIT)) begin
                    state_d = ST_RUN;
                    cnt_d   = '0;
                end
            end
            ST_RUN, ST_ERR: begin
                if (reinit_ok) begin
                    state_d = ST_HOLD;
                    att_d   = 2'd0;
                end
            end
            default: state_d = ST_HOLD;
        endcase

        lcd_rst_d = !((state_d == ST_HOLD) || (state_d == ST_SAMPLE));
        run_d     = (state_d == ST_RUN);
        id_err_d  = (state_d == ST_ERR);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_HOLD;
            cnt_q     <= '0;
            gap_q     <= '0;
            nsmp_q    <= 2'd0;
            att_q     <= 2'd0;
            s0_q      <= 3'd0;
            s1_q      <= 3'd0;
            s2_q      <= 3'd0;
            id_q      <= 16'h0000;
            h_q       <= 11'd0;
            v_q       <= 11'd0;
            lcd_rst_q <= 1'b0;
            run_q     <= 1'b0;
            id_err_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            gap_q     <= gap_d;
            nsmp_q    <= nsmp_d;
            att_q     <= att_d;
            s0_q      <= s0_d;
            s1_q      <= s1_d;
            s2_q      <= s2_d;
            id_q      <= id_d;
            h_q       <= h_d;
            v_q       <= v_d;
            lcd_rst_q <= lcd_rst_d;
            run_q     <= run_d;
            id_err_q  <= id_err_d;
        end
    end

    lcd_bl_pwm #(
        .RAMP_STEP(RAMP_STEP)
    ) u_pwm (
        .clk   (clk),
        .rst   (rst),
        .enable(run_q),
        .clr   (reinit_ok),
        .target(bl_level),
        .lcd_bl(lcd_bl)
    );

    assign lcd_rst   = lcd_rst_q;
    assign rgb_oe    = run_q;
    assign drv_en    = run_q;
    assign init_done = run_q;
    assign id_err    = id_err_q;
    assign id_lcd    = id_q;
    assign h_disp    = h_q;
    assign v_disp    = v_q;

endmodule

// File: doc/lcd_init_ctrl.md
# lcd_init_ctrl

Power-up and configuration sequencer for the RGB LCD path. It holds the panel in reset, reads the panel strap ID from the `lcd_rgb` bus while the bus is tri-stated, and publishes the ID with the matching active resolution. It then releases panel reset, enables the timing driver and ramps the backlight PWM to the requested level. It sits between the top-level `lcd_rgb` inout/pad logic and the LCD timing driver and clock divider, which consume `id_lcd`.

## Interface
- `RST_HOLD` = 5000: cycles `lcd_rst` is held low after reset or re-init.
- `SAMPLE_GAP` = 1000: cycles between ID samples; the first sample is also taken after this gap.
- `RELEASE_WAIT` = 5000: cycles from `lcd_rst` release to `drv_en`.
- `RAMP_STEP` = 256: cycles per one-LSB step of the backlight duty ramp.
- `clk` in 1: system clock. One clock domain.
- `rst` in 1: reset. Synchronous, active-high.
- `lcd_rgb_in` in 16: pad input side of `lcd_rgb`.
- `bl_level` in 8: target backlight duty, 0..255. Sampled continuously.
- `reinit` in 1: single-cycle pulse that restarts the sequence. Ignored unless in RUN or ERR.
- `rgb_oe` out 1: output enable for the top to gate the `lcd_rgb` driver. 0 until `drv_en`.
- `lcd_rst` out 1: panel reset, active low.
- `drv_en` out 1: timing-driver enable.
- `lcd_bl` out 1: backlight PWM.
- `id_lcd` out 16: decoded panel ID.
- `h_disp` out 11: active width for the ID.
- `v_disp` out 11: active height for the ID.
- `init_done` out 1: high in RUN.
- `id_err` out 1: high in ERR.

## Operation
- Strap code is `m = {lcd_rgb_in[4], lcd_rgb_in[10], lcd_rgb_in[15]}`. Decode:
  - 000 → 16'h4342, 480×272
  - 001 → 16'h7084, 800×480
  - 010 → 16'h7016, 1024×600
  - 100 → 16'h4384, 800×480
  - 101 → 16'h1018, 1280×800
  - 011, 110, 111 → invalid
- FSM states: HOLD, SAMPLE, RELEASE, RUN, ERR.
  - **HOLD:** `lcd_rst`=0, `rgb_oe`=0, duty=0. After `RST_HOLD` cycles → SAMPLE.
  - **SAMPLE:** take 3 samples of `m`, each after `SAMPLE_GAP` cycles.
    - All 3 equal and valid → latch `id_lcd`/`h_disp`/`v_disp` → RELEASE.
    - Mismatch or invalid → retry. The attempt counter holds at most 3 attempts.
    - After the 3rd failed attempt → ERR.
  - **RELEASE:** `lcd_rst`=1. After `RELEASE_WAIT` cycles → RUN.
  - **RUN:** `drv_en`=1, `rgb_oe`=1, `init_done`=1. Backlight duty ramps toward `bl_level`.
    - +1 or −1 every `RAMP_STEP` cycles. Never overshoots.
    - If `bl_level` changes mid-ramp, the ramp retargets.
  - **ERR:** `id_err`=1. Latch default 16'h4342 / 480×272. `lcd_rst`=1, `drv_en`=0, `lcd_bl`=0, `rgb_oe`=0.
- `reinit` in RUN or ERR → HOLD.
  - Clears duty (`lcd_bl` low immediately), the attempt counter, `init_done` and `id_err`.
  - `id_lcd`, `h_disp` and `v_disp` keep their last value until a new latch.
- PWM: 8-bit free-running counter `pc`. `lcd_bl` = (`pc` < duty).
  - duty 0 → constantly 0.
  - duty 255 → high 255 of 256 cycles.
- `rst` has priority over everything, including `reinit` in the same cycle.

## Timing
- Reset values: state HOLD, `lcd_rst`=0, `rgb_oe`=0, `drv_en`=0, `lcd_bl`=0, `init_done`=0, `id_err`=0, `id_lcd`=16'h0000, `h_disp`=0, `v_disp`=0.
- All outputs are registered.
  - State-derived outputs change on the first edge in the new state.
  - The ID/resolution registers update on the same edge as the entry into RELEASE.
- Minimum sequence to RUN: `RST_HOLD` + 3·`SAMPLE_GAP` + `RELEASE_WAIT` cycles, ±1 cycle per state transition (fixed, documented in the bench).
- Nominal power-up: `rst` deassert → `drv_en` = 5000 + 3000 + 5000 + 3 cycles = 13003. The +3 is one cycle per HOLD→SAMPLE, SAMPLE→RELEASE and RELEASE→RUN transition.
- Ramp to `bl_level`=N from 0 takes N·`RAMP_STEP` cycles.
- Counter widths: each counter uses `$clog2` of its parameter plus 1 bit. There is no wrap within a state, because counters reset on every state entry.

## Structure
- Package `lcd_pkg`:
  - panel ID constants
  - strap-code localparams
  - state enum
  - function `id_decode(m)` returning {valid, id, h, v}
- Sub-module `lcd_bl_pwm`: PWM counter, duty register and ramp logic. Inputs are `enable`, `target` and `clr`.
- The FSM stays in `lcd_init_ctrl`.

## Test plan
- Strap 001, stable; `bl_level`=8; `RAMP_STEP`=4 → `drv_en` rises at cycle 13003; `id_lcd`=16'h7084, 800×480; `init_done`=1; duty reaches 8 after 32 cycles; `lcd_bl` high 8 of 256 cycles.
- Strap toggles between 000 and 010 on each sample → three failed attempts → `id_err`=1, `id_lcd`=16'h4342, `lcd_bl`=0, `drv_en`=0.
- Strap 111 (invalid) on attempt 1, then 101 → recovers on attempt 2; `id_lcd`=16'h1018, 1280×800.
- In RUN at duty 100, `bl_level` changes to 50 → duty decrements to 50 and stops; `bl_level`=0 → `lcd_bl` is constantly low.
- `reinit` pulse in RUN → next edge: `lcd_bl`=0, `drv_en`=0, `lcd_rst`=0; full sequence repeats.
- `rst` asserted mid-SAMPLE together with `reinit` → all outputs return to reset values; sequence restarts from HOLD.
